// File: rtl/coriolis_sink_pkg.sv
// Shared types and constants for the coriolis stream sink.
// The optional running checksum port is enabled by defining SINK_CHECKSUM_EN.
package coriolis_sink_pkg;

  localparam int STREAMW_DEF = 34;
  localparam int DEPTH_DEF   = 16;
  localparam int CNTW_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sink_state_t;

  // Ceiling log2, used to size FIFO pointers from the depth.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/coriolis_sink_fifo.sv
// Single-clock show-ahead FIFO: head always presents mem[rd_ptr].
// Storage is cleared on reset so the head reads zero while empty after reset.
module coriolis_sink_fifo
  import coriolis_sink_pkg::*;
#(
  parameter int WIDTH = STREAMW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       empty,
  output logic [clog2(DEPTH):0]      count,
  output logic [WIDTH-1:0]           head
);

  localparam int ADDRW = clog2(DEPTH);
  localparam logic [ADDRW:0]   FULL_CNT = (ADDRW + 1)'(DEPTH);
  localparam logic [ADDRW:0]   ONE_CNT  = (ADDRW + 1)'(1);
  localparam logic [ADDRW-1:0] ONE_PTR  = ADDRW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDRW-1:0] wr_ptr;
  logic [ADDRW-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer, occupancy and storage update; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + ONE_PTR;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/coriolis_stream_sink.sv
// Terminal collector for a TyTra kernel pipeline: accepts a fixed number of
// words from the last kernel node, buffers them and hands them to the host.
// Define SINK_CHECKSUM_EN to add the XOR checksum output.
module coriolis_stream_sink
  import coriolis_sink_pkg::*;
#(
  parameter int STREAMW = STREAMW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CNTW    = CNTW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNTW-1:0]    num_items,
  input  logic               ivalid_in1_s0,
  input  logic [STREAMW-1:0] in1_s0,
  output logic               oready,
  output logic               m_valid,
  output logic [STREAMW-1:0] m_data,
  input  logic               m_ready,
  output logic [CNTW-1:0]    items_accepted,
  output logic               busy,
`ifdef SINK_CHECKSUM_EN
  output logic [STREAMW-1:0] checksum,
`endif
  output logic               done
);

  localparam int ADDRW = clog2(DEPTH);
  localparam logic [ADDRW:0] ONE_CNT  = (ADDRW + 1)'(1);
  localparam logic [CNTW-1:0] ONE_ITEM = CNTW'(1);

  sink_state_t     state;
  sink_state_t     state_next;
  logic [CNTW-1:0] num_q;
  logic [CNTW-1:0] count_after;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ADDRW:0]  fifo_count;
  logic            start_take;

  coriolis_sink_fifo #(
    .WIDTH (STREAMW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in1_s0),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (m_data)
  );

  // Handshake: oready only depends on registered state, so it never falls
  // speculatively within a cycle.
  assign oready     = (state == ST_RUN) & ~fifo_full & (items_accepted < num_q);
  assign push       = ivalid_in1_s0 & oready;
  assign m_valid    = ~fifo_empty;
  assign pop        = m_valid & m_ready & ((state == ST_RUN) | (state == ST_DRAIN));
  assign start_take = (state == ST_IDLE) & start;
  assign count_after = push ? (items_accepted + ONE_ITEM) : items_accepted;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state looks one push/pop ahead so DRAIN and DONE land one cycle
  // after the last push and the final pop respectively.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (count_after == num_q) state_next = ST_DRAIN;
      ST_DRAIN: if (fifo_empty | ((fifo_count == ONE_CNT) & pop)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Run length latch and accepted-item counter; the counter cannot pass
  // num_q because oready drops once they match.
  always_ff @(posedge clk) begin
    if (!rst) begin
      num_q          <= '0;
      items_accepted <= '0;
    end else if (start_take) begin
      num_q          <= num_items;
      items_accepted <= '0;
    end else if (push) begin
      items_accepted <= items_accepted + ONE_ITEM;
    end
  end

  // Registered status flags derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == ST_RUN) | (state_next == ST_DRAIN);
      done <= (state_next == ST_DONE);
    end
  end

`ifdef SINK_CHECKSUM_EN
  // Running XOR of every accepted word, restarted by each taken start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      checksum <= '0;
    end else if (start_take) begin
      checksum <= '0;
    end else if (push) begin
      checksum <= checksum ^ in1_s0;
    end
  end
`endif

endmodule
